seq_recognizer_param: RTL and testbench

Parametrised serial bit-pattern recognizer: successor to the fixed-pattern `recognizer`. Samples a serial stream `x` one bit per qualified clock and pulses `z` when the last `LEN` bits equal a runtime-loadable pattern. Supports overlapping and non-overlapping detection and keeps a saturating match counter. Sits between a serial input front end and the control logic that consumes detection events.

---
 rtl/seq_recognizer_param.sv | 99 +++++++++
 tb/tb_seq_recognizer_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_recognizer_param.sv
// rtl/seq_recognizer_param.sv - serial bit-pattern recognizer with loadable pattern and match counter
module seq_recognizer_param #(
    parameter int              LEN       = 4,
    parameter logic [LEN-1:0]  PAT_RESET = 4'b1011,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    input  logic             overlap,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int                FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [LEN-1:0]    pat;
    logic [LEN-1:0]    hist;
    logic [FILL_W-1:0] fill;

    logic [LEN-1:0]    pat_n;
    logic [LEN-1:0]    hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              z_n;
    logic [CNT_W-1:0]  cnt_n;

    logic [LEN-1:0]    nh;
    logic [FILL_W-1:0] nf;
    logic              hit;

    // Next-state: clear/pat_load restart the window, otherwise a qualified bit is shifted in and matched
    always_comb begin
        pat_n  = pat;
        hist_n = hist;
        fill_n = fill;
        z_n    = 1'b0;
        cnt_n  = match_count;

        // Newest bit enters at bit 0; the oldest bit falls off the top.
        nh  = LEN'({hist, x});
        nf  = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        hit = (nf == FILL_FULL) && (nh == pat);

        if (clear || pat_load) begin
            hist_n = '0;
            fill_n = '0;
            if (clear) begin
                cnt_n = '0;
            end
            if (pat_load) begin
                pat_n = pat_in;
            end
        end else if (x_valid) begin
            if (hit) begin
                z_n = 1'b1;
                if (match_count != {CNT_W{1'b1}}) begin
                    cnt_n = match_count + 1'b1;
                end
                if (overlap) begin
                    hist_n = nh;
                    fill_n = FILL_FULL;
                end else begin
                    // Matched bits are consumed; the next window starts empty.
                    hist_n = '0;
                    fill_n = '0;
                end
            end else begin
                hist_n = nh;
                fill_n = nf;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat         <= PAT_RESET;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else begin
            pat         <= pat_n;
            hist        <= hist_n;
            fill        <= fill_n;
            z           <= z_n;
            match_count <= cnt_n;
        end
    end

    assign armed = (fill == FILL_FULL);

endmodule

// File: tb/tb_seq_recognizer_param.sv
// tb/tb_seq_recognizer_param.sv - self-checking bench for seq_recognizer_param
module tb_seq_recognizer_param;

    localparam int LEN = 4;

    logic           clk;
    logic           reset;
    logic           x;
    logic           x_valid;
    logic           pat_load;
    logic [LEN-1:0] pat_in;
    logic           overlap;
    logic           clear;
    logic           z;
    logic [7:0]     match_count;
    logic           armed;
    logic           z2;
    logic [1:0]     match_count2;
    logic           armed2;

    int checks = 0;
    int errors = 0;

    seq_recognizer_param dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .clear(clear), .z(z),
        .match_count(match_count), .armed(armed)
    );

    seq_recognizer_param #(.LEN(4), .PAT_RESET(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .clear(clear), .z(z2),
        .match_count(match_count2), .armed(armed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic x;
        logic xv;
        logic ov;
        logic ez;
        int   ecnt;
    } vec_t;

    vec_t tbl[32];

    // Reference model: the consumed bits since the last restart, oldest first
    logic [LEN-1:0] m_pat;
    logic           m_bits[$];
    logic           m_z;
    int             m_cnt;
    int             m_cnt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic bx, input logic bxv, input logic bov, input logic bpl,
                         input logic [LEN-1:0] bpin, input logic bclr);
        x        = bx;
        x_valid  = bxv;
        overlap  = bov;
        pat_load = bpl;
        pat_in   = bpin;
        clear    = bclr;
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        pat_load = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic model_step(input logic mx, input logic mxv, input logic mov, input logic mpl,
                              input logic [LEN-1:0] mpin, input logic mclr);
        logic h;
        if (mclr || mpl) begin
            if (mclr) begin
                m_cnt  = 0;
                m_cnt2 = 0;
            end
            if (mpl) m_pat = mpin;
            m_bits.delete();
            m_z = 1'b0;
        end else if (mxv) begin
            m_bits.push_back(mx);
            if (m_bits.size() > LEN) void'(m_bits.pop_front());
            h = (m_bits.size() == LEN);
            for (int i = 0; i < m_bits.size(); i++) begin
                if (m_bits[i] != m_pat[LEN-1-i]) h = 1'b0;
            end
            m_z = h;
            if (h) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
                if (!mov) m_bits.delete();
            end
        end else begin
            m_z = 1'b0;
        end
    endtask

    initial begin
        logic [15:0]    stream;
        logic [15:0]    hit_ov;
        logic [15:0]    hit_no;
        logic [6:0]     ones_z;
        logic [6:0]     gap_x;
        logic [6:0]     gap_v;
        logic [3:0]     bits4;
        int             c;
        logic           rx, rxv, rov, rpl, rclr;
        logic [LEN-1:0] rpin;

        // Vector table: the test-plan stream, first overlapping then non-overlapping
        stream = 16'b0010_1101_0110_1101;
        hit_ov = 16'h0000;
        hit_ov[5] = 1'b1; hit_ov[10] = 1'b1; hit_ov[13] = 1'b1;
        hit_no = 16'h0000;
        hit_no[5] = 1'b1; hit_no[10] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            c = 0;
            for (int i = 0; i < 16; i++) begin
                tbl[r*16+i].x  = stream[15-i];
                tbl[r*16+i].xv = 1'b1;
                tbl[r*16+i].ov = (r == 0);
                tbl[r*16+i].ez = (r == 0) ? hit_ov[i] : hit_no[i];
                if (tbl[r*16+i].ez) c++;
                tbl[r*16+i].ecnt = c;
            end
        end

        x = 0; x_valid = 0; overlap = 1; pat_load = 0; pat_in = '0; clear = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", {31'd0, z}, 0);
        check("reset_cnt", {24'd0, match_count}, 0);
        check("reset_armed", {31'd0, armed}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            if (i == 16) drive(0, 0, 0, 0, '0, 1);
            drive(tbl[i].x, tbl[i].xv, tbl[i].ov, 0, '0, 0);
            check($sformatf("tbl_z[%0d]", i), {31'd0, z}, {31'd0, tbl[i].ez});
            check($sformatf("tbl_cnt[%0d]", i), {24'd0, match_count}, tbl[i].ecnt);
        end

        // All-ones pattern with overlap: back-to-back pulses and counter saturation on the narrow instance
        drive(0, 0, 1, 1, 4'b1111, 1);
        ones_z = 7'b0001111;
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 1, 0, '0, 0);
            check($sformatf("ones_z[%0d]", i), {31'd0, z}, {31'd0, ones_z[6-i]});
        end
        check("ones_cnt", {24'd0, match_count}, 4);
        check("ones_cnt_sat", {30'd0, match_count2}, 3);

        // Gaps in x_valid do not break a partial match
        drive(0, 0, 1, 1, 4'b1011, 1);
        gap_x = 7'b1010001;
        gap_v = 7'b1110001;
        for (int i = 0; i < 7; i++) begin
            drive(gap_x[6-i], gap_v[6-i], 1, 0, '0, 0);
            check($sformatf("gap_z[%0d]", i), {31'd0, z}, (i == 6) ? 1 : 0);
        end
        check("gap_cnt", {24'd0, match_count}, 1);

        // Asynchronous reset mid-cycle after a partial match
        drive(1, 1, 1, 0, '0, 0);
        drive(0, 1, 1, 0, '0, 0);
        drive(1, 1, 1, 0, '0, 0);
        #3 reset = 1'b0;
        #1;
        check("async_cnt", {24'd0, match_count}, 0);
        check("async_z", {31'd0, z}, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 1, 0, '0, 0);
        check("post_rst_z", {31'd0, z}, 0);
        check("post_rst_cnt", {24'd0, match_count}, 0);
        check("post_rst_armed", {31'd0, armed}, 0);

        // clear and pat_load together: counter zero, new pattern, empty window
        drive(1, 1, 1, 1, 4'b0110, 1);
        check("cl_pl_cnt", {24'd0, match_count}, 0);
        check("cl_pl_armed", {31'd0, armed}, 0);
        bits4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            drive(bits4[3-i], 1, 1, 0, '0, 0);
            check($sformatf("cl_pl_armed[%0d]", i), {31'd0, armed}, (i == 3) ? 1 : 0);
            check($sformatf("cl_pl_z[%0d]", i), {31'd0, z}, (i == 3) ? 1 : 0);
        end

        // Randomised run against the reference model
        drive(0, 0, 1, 1, 4'b1011, 1);
        model_step(0, 0, 1, 1, 4'b1011, 1);
        for (int n = 0; n < 3000; n++) begin
            rx   = 1'($urandom_range(0, 1));
            rxv  = ($urandom_range(0, 99) < 80);
            rov  = ($urandom_range(0, 99) < 60);
            rpl  = ($urandom_range(0, 99) < 2);
            rclr = ($urandom_range(0, 99) < 2);
            rpin = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            drive(rx, rxv, rov, rpl, rpin, rclr);
            model_step(rx, rxv, rov, rpl, rpin, rclr);
            check("rnd_z", {31'd0, z}, {31'd0, m_z});
            check("rnd_cnt", {24'd0, match_count}, m_cnt);
            check("rnd_cnt2", {30'd0, match_count2}, m_cnt2);
            check("rnd_armed", {31'd0, armed}, (m_bits.size() == LEN) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
